// File: rtl/ras_pkg.sv
// ras_pkg -- shared return-address-stack checkpoint definitions.
//   The checkpoint is packed as {ptr, count, tos}. The instruction queue
//   stores one of these per in-flight branch and hands it back on a
//   mispredict, so both sides must agree on field order and widths.
//   Default-geometry typedef plus a width helper for other geometries.
package ras_pkg;

  localparam int RAS_DEPTH = 16;
  localparam int RAS_AW    = 17;
  localparam int RAS_PW    = $clog2(RAS_DEPTH);

  // Field order is the contract: ptr in the MSBs, tos in the LSBs.
  typedef struct packed {
    logic [RAS_PW-1:0] ptr;
    logic [RAS_PW:0]   count;
    logic [RAS_AW-1:0] tos;
  } ras_ckpt_t;

  // Checkpoint width for an arbitrary geometry: ptr + count + tos.
  function automatic int ras_ckpt_w(input int depth, input int aw);
    return 2 * $clog2(depth) + 1 + aw;
  endfunction

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack -- circular return-address stack for call/return prediction.
//   clk, rst          : single clock, synchronous active-high reset
//   push, push_addr   : predicted call, address to push
//   pop               : predicted return, consumes top this cycle
//   flush             : drop all entries (count only; ptr/mem kept)
//   restore,
//   restore_ckpt      : repair {ptr, count, tos} after a mispredict
//   top, top_valid    : current top-of-stack (pre-update state)
//   ckpt              : current {ptr, count, top} snapshot
//   overflow          : 1-cycle pulse, a push overwrote the oldest entry
//   underflow         : 1-cycle pulse, a pop arrived on an empty stack
module return_addr_stack
  import ras_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int AW    = 17,
  localparam int PW    = $clog2(DEPTH),
  localparam int CKW   = ras_ckpt_w(DEPTH, AW)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [AW-1:0]  push_addr,
  input  logic           flush,
  input  logic           restore,
  input  logic [CKW-1:0] restore_ckpt,
  output logic [AW-1:0]  top,
  output logic           top_valid,
  output logic [CKW-1:0] ckpt,
  output logic           overflow,
  output logic           underflow
);

  typedef struct packed {
    logic [PW-1:0] ptr;
    logic [PW:0]   count;
    logic [AW-1:0] tos;
  } ckpt_t;

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  logic [PW:0]   count;
  ckpt_t         rc;

  // Single write port into mem, selected by priority below.
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic [AW-1:0] wr_data;

  assign rc        = ckpt_t'(restore_ckpt);
  assign top       = mem[ptr];
  assign top_valid = (count != '0);
  assign ckpt      = {ptr, count, top};

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = push_addr;
    if (rst) begin
      // Only slot 0 is cleared so top reads 0 straight out of reset.
      wr_en   = 1'b1;
      wr_idx  = '0;
      wr_data = '0;
    end else if (restore) begin
      // A wrong-path push may have clobbered the checkpointed TOS slot.
      wr_en   = 1'b1;
      wr_idx  = rc.ptr;
      wr_data = rc.tos;
    end else if (flush) begin
      wr_en   = 1'b0;
    end else if (push && pop) begin
      // Coroutine jalr: replace TOS in place.
      wr_en   = 1'b1;
    end else if (push) begin
      wr_en   = 1'b1;
      wr_idx  = ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      if (restore) begin
        ptr   <= rc.ptr;
        count <= rc.count;
      end else if (flush) begin
        count <= '0;
      end else if (push && pop) begin
        if (count == '0) count <= (PW+1)'(1);
      end else if (push) begin
        // Pointer wraps naturally; a full stack loses its oldest entry.
        ptr <= ptr + PW'(1);
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + (PW+1)'(1);
      end else if (pop) begin
        if (count != '0) begin
          ptr   <= ptr - PW'(1);
          count <= count - (PW+1)'(1);
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

  localparam int D   = 4;
  localparam int AW  = 17;
  localparam int PW  = $clog2(D);
  localparam int CKW = 2 * PW + 1 + AW;

  logic           clk = 1'b0;
  logic           rst, push, pop, flush, restore;
  logic [AW-1:0]  push_addr;
  logic [CKW-1:0] restore_ckpt;
  logic [AW-1:0]  top;
  logic           top_valid, overflow, underflow;
  logic [CKW-1:0] ckpt;

  int total = 0;
  int bad   = 0;

  return_addr_stack #(.DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
    .flush(flush), .restore(restore), .restore_ckpt(restore_ckpt),
    .top(top), .top_valid(top_valid), .ckpt(ckpt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Reference model: stack of return addresses in a ring of D slots.
  int  m_mem [D];
  bit  m_known [D];
  int  m_ptr, m_cnt;
  bit  m_ov, m_un;

  function automatic logic [CKW-1:0] m_ckpt();
    logic [CKW-1:0] v;
    v = CKW'(m_ptr) << (PW + 1 + AW);
    v = v | (CKW'(m_cnt) << AW);
    v = v | CKW'(m_mem[m_ptr]);
    return v;
  endfunction

  task automatic model_step(input bit r, input bit pu, input bit po, input int a,
                            input bit fl, input bit rs, input logic [CKW-1:0] rc);
    int rp, rcnt, rt;
    rp   = int'(rc >> (PW + 1 + AW)) % D;
    rcnt = int'((rc >> AW) & ((1 << (PW + 1)) - 1));
    rt   = int'(rc & ((1 << AW) - 1));
    if (r) begin
      m_ptr = 0; m_cnt = 0; m_mem[0] = 0; m_known[0] = 1; m_ov = 0; m_un = 0;
    end else begin
      m_ov = 0; m_un = 0;
      if (rs) begin
        m_ptr = rp; m_cnt = rcnt; m_mem[rp] = rt; m_known[rp] = 1;
      end else if (fl) begin
        m_cnt = 0;
      end else if (pu && po) begin
        m_mem[m_ptr] = a; m_known[m_ptr] = 1;
        if (m_cnt == 0) m_cnt = 1;
      end else if (pu) begin
        m_ptr = (m_ptr + 1) % D;
        m_mem[m_ptr] = a; m_known[m_ptr] = 1;
        if (m_cnt == D) m_ov = 1; else m_cnt++;
      end else if (po) begin
        if (m_cnt > 0) begin m_ptr = (m_ptr + D - 1) % D; m_cnt--; end
        else m_un = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt"}, 64'(ckpt[AW +: PW+1]), 64'(m_cnt));
    chk({tag, ".ptr"}, 64'(ckpt[CKW-1 -: PW]), 64'(m_ptr));
    chk({tag, ".tv"},  64'(top_valid), 64'(m_cnt != 0));
    chk({tag, ".ov"},  64'(overflow), 64'(m_ov));
    chk({tag, ".un"},  64'(underflow), 64'(m_un));
    if (m_known[m_ptr]) begin
      chk({tag, ".top"},  64'(top), 64'(m_mem[m_ptr]));
      chk({tag, ".ckpt"}, 64'(ckpt), 64'(m_ckpt()));
    end
  endtask

  // Drive one cycle of inputs at negedge, clock it, check at next negedge.
  task automatic step(input string tag, input bit r, input bit pu, input bit po,
                      input int a, input bit fl = 0, input bit rs = 0,
                      input logic [CKW-1:0] rc = '0);
    rst = r; push = pu; pop = po; push_addr = AW'(a);
    flush = fl; restore = rs; restore_ckpt = rc;
    @(posedge clk);
    model_step(r, pu, po, a, fl, rs, rc);
    @(negedge clk);
    rst = 0; push = 0; pop = 0; flush = 0; restore = 0;
    chk_model(tag);
  endtask

  function automatic logic [CKW-1:0] mk(input int p, input int c, input int t);
    return (CKW'(p) << (PW + 1 + AW)) | (CKW'(c) << AW) | CKW'(t);
  endfunction

  logic [CKW-1:0] snap;
  int             op;

  initial begin
    rst = 0; push = 0; pop = 0; flush = 0; restore = 0;
    push_addr = '0; restore_ckpt = '0;
    for (int i = 0; i < D; i++) begin m_mem[i] = 0; m_known[i] = 0; end
    m_ptr = 0; m_cnt = 0; m_ov = 0; m_un = 0;
    @(negedge clk);

    // Reset state
    step("rst", 1, 0, 0, 0);
    chk("rst.top", 64'(top), 64'h0);
    chk("rst.ckpt", 64'(ckpt), 64'h0);

    // Basic push/pop ordering
    step("p1", 0, 1, 0, 'h100);
    step("p2", 0, 1, 0, 'h104);
    step("p3", 0, 1, 0, 'h108);
    chk("b.top", 64'(top), 64'h108);
    chk("b.cnt", 64'(ckpt[AW +: PW+1]), 64'd3);
    chk("b.pop1", 64'(top), 64'h108); step("q1", 0, 0, 1, 0);
    chk("b.pop2", 64'(top), 64'h104); step("q2", 0, 0, 1, 0);
    chk("b.pop3", 64'(top), 64'h100); step("q3", 0, 0, 1, 0);
    chk("b.tv", 64'(top_valid), 64'h0);

    // Overflow then drain to underflow
    step("orst", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("o", 0, 1, 0, 'h10 + i);
    chk("o.noov", 64'(overflow), 64'h0);
    step("o5", 0, 1, 0, 'h14);
    chk("o.ov", 64'(overflow), 64'h1);
    chk("o.cnt", 64'(ckpt[AW +: PW+1]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("o.drain", 64'(top), 64'('h14 - i));
      step("od", 0, 0, 1, 0);
    end
    snap = ckpt;
    step("o.under", 0, 0, 1, 0);
    chk("o.un", 64'(underflow), 64'h1);
    chk("o.same", 64'(ckpt), 64'(snap));
    step("o.unclr", 0, 0, 0, 0);
    chk("o.un0", 64'(underflow), 64'h0);

    // Push+pop in the same cycle
    step("cr", 1, 0, 0, 0);
    step("c1", 0, 1, 0, 'h200);
    step("c2", 0, 1, 1, 'h300);
    chk("c.top", 64'(top), 64'h300);
    chk("c.cnt", 64'(ckpt[AW +: PW+1]), 64'd1);
    step("c3", 0, 0, 1, 0);
    step("c4", 0, 1, 1, 'h300);
    chk("c.ecnt", 64'(ckpt[AW +: PW+1]), 64'd1);
    chk("c.etop", 64'(top), 64'h300);
    chk("c.eun", 64'(underflow), 64'h0);

    // Checkpoint / restore
    step("kr", 1, 0, 0, 0);
    step("kA", 0, 1, 0, 'hA);
    step("kB", 0, 1, 0, 'hB);
    snap = m_ckpt();
    chk("k.snap", 64'(snap), 64'(mk(2, 2, 'hB)));
    step("kC", 0, 1, 0, 'hC);
    step("kD", 0, 1, 0, 'hD);
    step("kp", 0, 0, 1, 0);
    step("krs", 0, 0, 0, 0, 0, 1, snap);
    chk("k.top", 64'(top), 64'hB);
    chk("k.cnt", 64'(ckpt[AW +: PW+1]), 64'd2);
    step("kp2", 0, 0, 1, 0);
    chk("k.top2", 64'(top), 64'hA);

    // Priority: restore over flush, flush alone, rst over push
    step("pf", 0, 1, 0, 'h55, 1, 1, mk(3, 3, 'h77));
    chk("pf.top", 64'(top), 64'h77);
    chk("pf.cnt", 64'(ckpt[AW +: PW+1]), 64'd3);
    step("fl", 0, 1, 1, 'h66, 1);
    chk("fl.tv", 64'(top_valid), 64'h0);
    for (int i = 0; i < 4; i++) step("fp", 0, 1, 0, 'h40 + i);
    step("rp", 1, 1, 0, 'h99);
    chk("rp.cnt", 64'(ckpt[AW +: PW+1]), 64'd0);
    chk("rp.top", 64'(top), 64'h0);
    chk("rp.ov", 64'(overflow), 64'h0);

    // Randomized traffic against the model
    snap = m_ckpt();
    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 99));
      if (op < 2)       step("rnd", 1, 1, 0, int'($urandom) & 'h1FFFF);
      else if (op < 6)  step("rnd", 0, $urandom_range(0, 1) == 1, 1'b0, 0, 0, 1, snap);
      else if (op < 10) step("rnd", 0, 1, 0, int'($urandom) & 'h1FFFF, 1);
      else if (op < 20) step("rnd", 0, 1, 1, int'($urandom) & 'h1FFFF);
      else if (op < 55) step("rnd", 0, 1, 0, int'($urandom) & 'h1FFFF);
      else if (op < 90) step("rnd", 0, 0, 1, 0);
      else              step("rnd", 0, 0, 0, 0);
      if (op % 7 == 0) snap = m_ckpt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
